// File: rtl/argmax_layer_seq_pkg.sv
// Shared types and helpers for the per-channel sequential argmax.
// No timing of its own; constants and functions only.
// No flow control.
package argmax_layer_seq_pkg;

  localparam int N_DEF        = 2;
  localparam int CHAR_NUM_DEF = 200;
  localparam int N_LEN_DEF    = 16;
  localparam int LANES_DEF    = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Index width that never collapses to zero bits (a 1-entry vector still needs a 1-bit index).
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/argmax_layer_seq_lane_tree.sv
// Signed max with lane index over one chunk of LANES elements; masked lanes never win.
// Combinational, zero latency.
// No flow control; evaluated every cycle by its owner.
module argmax_layer_seq_lane_tree
  import argmax_layer_seq_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int N_LEN = N_LEN_DEF
) (
  input  logic [LANES*N_LEN-1:0]            lane_dat,
  input  logic [LANES-1:0]                  lane_vld,
  output logic                              any_vld,
  output logic signed [N_LEN-1:0]           max_dat,
  output logic [clog2_min1(LANES)-1:0]      max_idx
);

  localparam int LW = clog2_min1(LANES);

  // Lowest lane is visited first and only a strictly greater value replaces it,
  // so equal values resolve to the lowest lane index.
  always_comb begin
    any_vld = 1'b0;
    max_dat = '0;
    max_idx = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_vld[i] && (!any_vld || ($signed(lane_dat[i*N_LEN +: N_LEN]) > max_dat))) begin
        any_vld = 1'b1;
        max_dat = lane_dat[i*N_LEN +: N_LEN];
        max_idx = LW'(i);
      end
    end
  end

endmodule

// File: rtl/argmax_layer_seq.sv
// Per-channel argmax (index and value) over N signed vectors, LANES elements per cycle.
// run accepted at edge k -> valid pulse after edge k+C, C = ceil(CHAR_NUM/LANES); back-to-back period C+1.
// No backpressure: run is ignored while scanning; results hold until the next valid or reset.
module argmax_layer_seq
  import argmax_layer_seq_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int CHAR_NUM = CHAR_NUM_DEF,
  parameter int N_LEN    = N_LEN_DEF,
  parameter int LANES    = LANES_DEF
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                run,
  input  logic [N*CHAR_NUM*N_LEN-1:0]         d,
  output logic                                busy,
  output logic                                valid,
  output logic [N*clog2_min1(CHAR_NUM)-1:0]   q,
  output logic [N*N_LEN-1:0]                  q_max
);

  localparam int CHAR_LEN = clog2_min1(CHAR_NUM);
  localparam int C        = ceil_div(CHAR_NUM, LANES);
  localparam int CW       = clog2_min1(C + 1);
  localparam int LW       = clog2_min1(LANES);
  localparam logic signed [N_LEN-1:0] MOST_NEG = {1'b1, {(N_LEN-1){1'b0}}};

  state_t                      state;
  state_t                      state_nxt;
  logic                        accept;
  logic                        last_chunk;
  logic [CW-1:0]               cnt;
  logic [N*CHAR_NUM*N_LEN-1:0] d_buf;

  assign last_chunk = (state == ST_SCAN) && (cnt == CW'(C - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state and status outputs; a run seen in DONE restarts without passing through IDLE.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b0;
    valid     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (run) begin
          accept    = 1'b1;
          state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        busy = 1'b1;
        if (cnt == CW'(C - 1)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        valid = 1'b1;
        if (run) begin
          accept    = 1'b1;
          state_nxt = ST_SCAN;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Chunk counter: restarts on accept, stops on the last chunk so it never wraps.
  always_ff @(posedge clk) begin
    if (!rst_n)                           cnt <= '0;
    else if (accept)                      cnt <= '0;
    else if ((state == ST_SCAN) && !last_chunk) cnt <= cnt + CW'(1);
  end

  // Input snapshot so d is free to change once a scan is accepted.
  always_ff @(posedge clk) begin
    if (accept) d_buf <= d;
  end

  for (genvar ch = 0; ch < N; ch++) begin : g_ch
    logic [LANES*N_LEN-1:0]  lane_dat;
    logic [LANES-1:0]        lane_vld;
    logic                    chunk_vld;
    logic signed [N_LEN-1:0] chunk_dat;
    logic [LW-1:0]           chunk_lane;
    logic [CHAR_LEN-1:0]     chunk_idx;
    logic                    best_vld;
    logic signed [N_LEN-1:0] best_dat;
    logic [CHAR_LEN-1:0]     best_idx;
    logic                    take;
    logic signed [N_LEN-1:0] fin_dat;
    logic [CHAR_LEN-1:0]     fin_idx;
    logic [CHAR_LEN-1:0]     q_reg;
    logic signed [N_LEN-1:0] qm_reg;

    // Chunk mux: one-hot on the counter; lanes past the vector end stay masked.
    always_comb begin
      lane_dat = '0;
      lane_vld = '0;
      for (int c = 0; c < C; c++) begin
        for (int l = 0; l < LANES; l++) begin
          if ((c*LANES + l < CHAR_NUM) && (cnt == CW'(c))) begin
            lane_vld[l]                  = 1'b1;
            lane_dat[l*N_LEN +: N_LEN]   = d_buf[(ch*CHAR_NUM + c*LANES + l)*N_LEN +: N_LEN];
          end
        end
      end
    end

    argmax_layer_seq_lane_tree #(
      .LANES (LANES),
      .N_LEN (N_LEN)
    ) u_tree (
      .lane_dat (lane_dat),
      .lane_vld (lane_vld),
      .any_vld  (chunk_vld),
      .max_dat  (chunk_dat),
      .max_idx  (chunk_lane)
    );

    assign chunk_idx = CHAR_LEN'(int'(cnt) * LANES + int'(chunk_lane));
    // Running best keeps its entry on equality: earlier chunks hold lower indices.
    assign take      = chunk_vld && (!best_vld || (chunk_dat > best_dat));
    assign fin_dat   = take ? chunk_dat : best_dat;
    assign fin_idx   = take ? chunk_idx : best_idx;

    // Running best per channel, emptied on every accepted run.
    always_ff @(posedge clk) begin
      if (!rst_n || accept) begin
        best_vld <= 1'b0;
        best_dat <= MOST_NEG;
        best_idx <= '0;
      end else if ((state == ST_SCAN) && take) begin
        best_vld <= 1'b1;
        best_dat <= chunk_dat;
        best_idx <= chunk_idx;
      end
    end

    // Result registers load the merged best on the final chunk and hold until the next one.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        q_reg  <= '0;
        qm_reg <= '0;
      end else if (last_chunk) begin
        q_reg  <= fin_idx;
        qm_reg <= fin_dat;
      end
    end

    assign q[ch*CHAR_LEN +: CHAR_LEN] = q_reg;
    assign q_max[ch*N_LEN +: N_LEN]   = qm_reg;
  end

endmodule

// File: tb/tb_argmax_layer_seq.sv
module tb_argmax_layer_seq;

  localparam int DW = 2 * 200 * 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  // Main instance: N=2, CHAR_NUM=200, LANES=8 (C=25)
  logic          run0;
  logic [DW-1:0] d0;
  logic          busy0, valid0;
  logic [15:0]   q0;
  logic [31:0]   qm0;

  // Short vector with a partial last chunk: CHAR_NUM=13, LANES=4 (C=4)
  logic          run1;
  logic [415:0]  d1;
  logic          busy1, valid1;
  logic [7:0]    q1;
  logic [31:0]   qm1;

  // Single-element vector: CHAR_NUM=1, LANES=1
  logic          run2;
  logic [31:0]   d2;
  logic          busy2, valid2;
  logic [1:0]    q2;
  logic [31:0]   qm2;

  // Random-regression instances sharing one stimulus: LANES 1, 7, 200
  logic          run_r;
  logic [DW-1:0] d_r;
  logic          busy_a, valid_a, busy_b, valid_b, busy_c, valid_c;
  logic [15:0]   q_a, q_b, q_c;
  logic [31:0]   qm_a, qm_b, qm_c;

  argmax_layer_seq #(.N(2), .CHAR_NUM(200), .N_LEN(16), .LANES(8)) u_main (
    .clk(clk), .rst_n(rst_n), .run(run0), .d(d0),
    .busy(busy0), .valid(valid0), .q(q0), .q_max(qm0));

  argmax_layer_seq #(.N(2), .CHAR_NUM(13), .N_LEN(16), .LANES(4)) u_small (
    .clk(clk), .rst_n(rst_n), .run(run1), .d(d1),
    .busy(busy1), .valid(valid1), .q(q1), .q_max(qm1));

  argmax_layer_seq #(.N(2), .CHAR_NUM(1), .N_LEN(16), .LANES(1)) u_one (
    .clk(clk), .rst_n(rst_n), .run(run2), .d(d2),
    .busy(busy2), .valid(valid2), .q(q2), .q_max(qm2));

  argmax_layer_seq #(.N(2), .CHAR_NUM(200), .N_LEN(16), .LANES(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .run(run_r), .d(d_r),
    .busy(busy_a), .valid(valid_a), .q(q_a), .q_max(qm_a));

  argmax_layer_seq #(.N(2), .CHAR_NUM(200), .N_LEN(16), .LANES(7)) u_l7 (
    .clk(clk), .rst_n(rst_n), .run(run_r), .d(d_r),
    .busy(busy_b), .valid(valid_b), .q(q_b), .q_max(qm_b));

  argmax_layer_seq #(.N(2), .CHAR_NUM(200), .N_LEN(16), .LANES(200)) u_l200 (
    .clk(clk), .rst_n(rst_n), .run(run_r), .d(d_r),
    .busy(busy_c), .valid(valid_c), .q(q_c), .q_max(qm_c));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain first-maximum search over each channel's elements, two channels.
  task automatic ref_model(input logic [DW-1:0] v, input int cn, input int cl,
                           output logic [63:0] eq, output logic [63:0] eqm);
    int          bi;
    logic [15:0] bv;
    logic [15:0] e;
    eq  = '0;
    eqm = '0;
    for (int ch = 0; ch < 2; ch++) begin
      bi = 0;
      bv = v[ch*cn*16 +: 16];
      for (int j = 1; j < cn; j++) begin
        e = v[(ch*cn + j)*16 +: 16];
        if ($signed(e) > $signed(bv)) begin
          bv = e;
          bi = j;
        end
      end
      eq  = eq  | (64'(bi) << (ch*cl));
      eqm = eqm | (64'(bv) << (ch*16));
    end
  endtask

  task automatic rand_fill(output logic [DW-1:0] v, input int mode);
    int r;
    for (int i = 0; i < 400; i++) begin
      if (mode == 0) begin
        v[i*16 +: 16] = 16'($urandom);
      end else if (mode == 1) begin
        v[i*16 +: 16] = 16'($urandom_range(0, 3)) - 16'd2;
      end else begin
        r = $urandom_range(0, 2);
        v[i*16 +: 16] = (r == 0) ? 16'h8000 : (r == 1) ? 16'h7FFF : 16'h0000;
      end
    end
  endtask

  task automatic set0(input int ch, input int idx, input logic [15:0] val);
    d0[(ch*200 + idx)*16 +: 16] = val;
  endtask

  // One scan on the main instance with full latency, busy, result and hold checks.
  task automatic scan0(input string tag, input logic [63:0] eq, input logic [63:0] eqm);
    int edges;
    int busy_n;
    run0 = 1'b1;
    tick();
    run0   = 1'b0;
    edges  = 1;
    busy_n = 0;
    while (!valid0 && edges < 60) begin
      if (busy0) busy_n++;
      tick();
      edges++;
    end
    chk({tag, "_lat"}, 64'(edges), 64'd26);
    chk({tag, "_busy"}, 64'(busy_n), 64'd25);
    chk({tag, "_q"}, 64'(q0), eq);
    chk({tag, "_qmax"}, 64'(qm0), eqm);
    tick();
    chk({tag, "_pulse"}, 64'(valid0), 64'd0);
    chk({tag, "_hold"}, 64'({q0, qm0}), 64'({eq[15:0], eqm[31:0]}));
  endtask

  initial begin
    logic [63:0] eq, eqm, eq2, eqm2;
    logic [DW-1:0] tmp;
    int edges, n, nv, la, lb, lc;

    rst_n = 1'b0;
    run0 = 1'b0; run1 = 1'b0; run2 = 1'b0; run_r = 1'b0;
    d0 = '0; d1 = '0; d2 = '0; d_r = '0;
    repeat (3) tick();
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_valid", 64'(valid0), 64'd0);
    chk("rst_q", 64'(q0), 64'd0);
    chk("rst_qmax", 64'(qm0), 64'd0);
    rst_n = 1'b1;
    tick();

    // 1: distinct maxima at 137 (ch0) and at the last element (ch1)
    for (int i = 0; i < 200; i++) begin
      set0(0, i, 16'($urandom_range(0, 255)) - 16'd300);
      set0(1, i, 16'($urandom_range(0, 30000)));
    end
    set0(0, 137, 16'h0100);
    set0(1, 199, 16'h7FFF);
    scan0("t1", 64'({8'd199, 8'd137}), 64'({16'h7FFF, 16'h0100}));

    // 2: all equal -> index 0; duplicate maximum -> lowest index
    for (int i = 0; i < 200; i++) begin
      set0(0, i, 16'hFFFB);
      set0(1, i, 16'h0000);
    end
    set0(1, 10, 16'd3);
    set0(1, 150, 16'd3);
    scan0("t2", 64'({8'd10, 8'd0}), 64'({16'd3, 16'hFFFB}));

    // 3a: every element is the most negative value
    for (int i = 0; i < 200; i++) begin
      set0(0, i, 16'h8000);
      set0(1, i, 16'h8000);
    end
    scan0("t3a", 64'd0, 64'({16'h8000, 16'h8000}));

    // 3b: partial last chunk, maximum on the final element
    for (int i = 0; i < 26; i++) d1[i*16 +: 16] = 16'($urandom_range(0, 1000)) - 16'd2000;
    d1[12*16 +: 16] = 16'h7000;
    tmp = '0;
    tmp[415:0] = d1;
    ref_model(tmp, 13, 4, eq, eqm);
    run1 = 1'b1;
    tick();
    run1  = 1'b0;
    edges = 1;
    while (!valid1 && edges < 30) begin tick(); edges++; end
    chk("t3b_lat", 64'(edges), 64'd5);
    chk("t3b_q0", 64'(q1[3:0]), 64'd12);
    chk("t3b_q", 64'(q1), eq);
    chk("t3b_qmax", 64'(qm1), eqm);

    // 4: mid-scan run and data change are ignored
    rand_fill(tmp, 0);
    d0 = tmp;
    ref_model(d0, 200, 8, eq, eqm);
    run0 = 1'b1;
    tick();
    run0  = 1'b0;
    edges = 1;
    repeat (9) begin tick(); edges++; end
    rand_fill(tmp, 0);
    d0   = tmp;
    run0 = 1'b1;
    tick();
    edges++;
    run0 = 1'b0;
    while (!valid0 && edges < 60) begin tick(); edges++; end
    chk("t4_lat", 64'(edges), 64'd26);
    chk("t4_q", 64'(q0), eq);
    chk("t4_qmax", 64'(qm0), eqm);
    nv = 0;
    repeat (40) begin tick(); if (valid0) nv++; end
    chk("t4_novalid", 64'(nv), 64'd0);

    // 4b: run held high -> back-to-back scans every 26 cycles
    ref_model(d0, 200, 8, eq2, eqm2);
    run0 = 1'b1;
    tick();
    edges = 1;
    while (!valid0 && edges < 60) begin tick(); edges++; end
    chk("t4b_lat", 64'(edges), 64'd26);
    n = 0;
    do begin tick(); n++; end while (!valid0 && n < 60);
    chk("t4b_period", 64'(n), 64'd26);
    chk("t4b_q", 64'(q0), eq2);
    chk("t4b_qmax", 64'(qm0), eqm2);
    run0 = 1'b0;
    nv = 0;
    repeat (30) begin tick(); if (valid0) nv++; end
    chk("t4b_novalid", 64'(nv), 64'd0);

    // 5: reset mid-scan aborts the scan and clears the outputs
    rand_fill(tmp, 0);
    d0 = tmp;
    run0 = 1'b1;
    tick();
    run0 = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    chk("t5_busy", 64'(busy0), 64'd0);
    chk("t5_valid", 64'(valid0), 64'd0);
    chk("t5_q", 64'(q0), 64'd0);
    chk("t5_qmax", 64'(qm0), 64'd0);
    rst_n = 1'b1;
    nv = 0;
    repeat (40) begin tick(); if (valid0) nv++; end
    chk("t5_novalid", 64'(nv), 64'd0);
    rand_fill(tmp, 1);
    d0 = tmp;
    ref_model(d0, 200, 8, eq, eqm);
    scan0("t5_fresh", eq, eqm);

    // CHAR_NUM=1: index always 0, value is element 0
    for (int k = 0; k < 4; k++) begin
      d2   = $urandom;
      run2 = 1'b1;
      tick();
      run2  = 1'b0;
      edges = 1;
      while (!valid2 && edges < 20) begin tick(); edges++; end
      chk("one_lat", 64'(edges), 64'd2);
      chk("one_q", 64'(q2), 64'd0);
      chk("one_qmax", 64'(qm2), 64'(d2));
    end

    // 6: random vectors against the reference model, three lane counts in parallel
    for (int it = 0; it < 200; it++) begin
      rand_fill(tmp, it % 3);
      d_r = tmp;
      ref_model(d_r, 200, 8, eq, eqm);
      run_r = 1'b1;
      tick();
      run_r = 1'b0;
      edges = 1;
      la = 0; lb = 0; lc = 0;
      if (valid_c) lc = edges;
      while ((la == 0 || lb == 0 || lc == 0) && edges < 260) begin
        tick();
        edges++;
        if (valid_a && la == 0) la = edges;
        if (valid_b && lb == 0) lb = edges;
        if (valid_c && lc == 0) lc = edges;
      end
      chk("r_l1_lat", 64'(la), 64'd201);
      chk("r_l7_lat", 64'(lb), 64'd30);
      chk("r_l200_lat", 64'(lc), 64'd2);
      chk("r_l1_q", 64'(q_a), eq);
      chk("r_l1_qmax", 64'(qm_a), eqm);
      chk("r_l7_q", 64'(q_b), eq);
      chk("r_l7_qmax", 64'(qm_b), eqm);
      chk("r_l200_q", 64'(q_c), eq);
      chk("r_l200_qmax", 64'(qm_c), eqm);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
